// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel down-counting timer stepped by one shared prescaler
// Define TIMER_MULTI_PWM_EN to enable the per-channel registered PWM comparator.
module timer_multi #(
   parameter int WIDTH      = 16,
   parameter int CHANNELS   = 2,
   parameter int PRESCALE_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PRESCALE_W-1:0]     prescale,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       periodic,
   input  logic [CHANNELS*WIDTH-1:0] reload,
   input  logic [CHANNELS*WIDTH-1:0] compare,
   input  logic [CHANNELS-1:0]       irq_clr,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       running,
   output logic [CHANNELS-1:0]       expired,
   output logic [CHANNELS-1:0]       irq,
   output logic [CHANNELS-1:0]       pwm
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   logic [PRESCALE_W-1:0]     pcnt_q, pcnt_d;
   logic                      tick;
   state_t                    state_q [CHANNELS];
   state_t                    state_d [CHANNELS];
   logic [CHANNELS-1:0]       mode_q, mode_d;
   logic [CHANNELS-1:0]       expired_q, expired_d;
   logic [CHANNELS-1:0]       irq_q, irq_d;
   logic [CHANNELS-1:0]       pwm_q, pwm_d;
   logic [CHANNELS*WIDTH-1:0] count_q, count_d;

   // >= so that lowering prescale below the current phase wraps at once
   always_comb begin
      tick   = (pcnt_q >= prescale);
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
   end

   always_comb begin
      count_d   = count_q;
      mode_d    = mode_q;
      expired_d = '0;
      irq_d     = irq_q;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         if (stop[i]) begin
            if (state_q[i] == ST_RUN) begin
               state_d[i] = ST_IDLE;
            end
         end else if (start[i]) begin
            state_d[i]                 = ST_RUN;
            mode_d[i]                  = periodic[i];
            count_d[i*WIDTH +: WIDTH]  = reload[i*WIDTH +: WIDTH];
         end else if (state_q[i] == ST_RUN && tick) begin
            if (count_q[i*WIDTH +: WIDTH] != '0) begin
               count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] - 1'b1;
            end else begin
               expired_d[i] = 1'b1;
               if (mode_q[i]) begin
                  count_d[i*WIDTH +: WIDTH] = reload[i*WIDTH +: WIDTH];
               end else begin
                  state_d[i] = ST_DONE;
               end
            end
         end
         // a fresh expiry overrides a simultaneous clear
         irq_d[i] = expired_d[i] | (irq_q[i] & ~irq_clr[i]);
      end
   end

`ifdef TIMER_MULTI_PWM_EN
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = (state_q[i] == ST_RUN) && (count_q[i*WIDTH +: WIDTH] < compare[i*WIDTH +: WIDTH]);
      end
   end
`else
   logic unused_compare;
   assign unused_compare = ^compare;
   assign pwm_d          = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_q    <= '0;
         count_q   <= '0;
         mode_q    <= '0;
         expired_q <= '0;
         irq_q     <= '0;
         pwm_q     <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_IDLE;
         end
      end else begin
         pcnt_q    <= pcnt_d;
         count_q   <= count_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
         irq_q     <= irq_d;
         pwm_q     <= pwm_d;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      running = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         running[i] = (state_q[i] == ST_RUN);
      end
   end

   assign count   = count_q;
   assign expired = expired_q;
   assign irq     = irq_q;
   assign pwm     = pwm_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - directed and randomized checks of timer_multi against a behavioural model
// PWM expectations follow TIMER_MULTI_PWM_EN when the bench is built with it.
module tb_timer_multi;
   localparam int WIDTH      = 16;
   localparam int CHANNELS   = 2;
   localparam int PRESCALE_W = 8;
`ifdef TIMER_MULTI_PWM_EN
   localparam bit PWM_EN = 1'b1;
`else
   localparam bit PWM_EN = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      reset;
   logic [PRESCALE_W-1:0]     prescale;
   logic [CHANNELS-1:0]       start, stop, periodic, irq_clr;
   logic [CHANNELS*WIDTH-1:0] reload, compare;
   logic [CHANNELS*WIDTH-1:0] count;
   logic [CHANNELS-1:0]       running, expired, irq, pwm;

   int errors = 0;
   int checks = 0;

   int m_since;
   int m_cnt [CHANNELS];
   bit m_run [CHANNELS];
   bit m_per [CHANNELS];
   bit m_irq [CHANNELS];
   bit m_exp [CHANNELS];
   bit m_pwm [CHANNELS];

   timer_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)) dut (
      .clk(clk), .reset(reset), .prescale(prescale), .start(start), .stop(stop),
      .periodic(periodic), .reload(reload), .compare(compare), .irq_clr(irq_clr),
      .count(count), .running(running), .expired(expired), .irq(irq), .pwm(pwm)
   );

   always #5 clk = ~clk;

   function automatic int rl(int i);
      return int'(reload[i*WIDTH +: WIDTH]);
   endfunction

   function automatic int cmpv(int i);
      return int'(compare[i*WIDTH +: WIDTH]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_since = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         m_cnt[i] = 0; m_run[i] = 0; m_per[i] = 0;
         m_irq[i] = 0; m_exp[i] = 0; m_pwm[i] = 0;
      end
   endtask

   // one clock edge of the timer's rules, applied to the inputs present at that edge
   task automatic model_step();
      bit tk;
      tk      = (m_since >= int'(prescale));
      m_since = tk ? 0 : m_since + 1;
      for (int i = 0; i < CHANNELS; i++) begin
         m_pwm[i] = PWM_EN && m_run[i] && (m_cnt[i] < cmpv(i));
         m_exp[i] = 0;
         if (stop[i]) begin
            m_run[i] = 0;
         end else if (start[i]) begin
            m_run[i] = 1; m_cnt[i] = rl(i); m_per[i] = periodic[i];
         end else if (m_run[i] && tk) begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            else begin
               m_exp[i] = 1;
               if (m_per[i]) m_cnt[i] = rl(i);
               else m_run[i] = 0;
            end
         end
         if (m_exp[i]) m_irq[i] = 1;
         else if (irq_clr[i]) m_irq[i] = 0;
      end
   endtask

   task automatic check_all(string ph);
      for (int i = 0; i < CHANNELS; i++) begin
         chk($sformatf("%s.count%0d", ph, i), 32'(count[i*WIDTH +: WIDTH]), 32'(m_cnt[i]));
         chk($sformatf("%s.running%0d", ph, i), 32'(running[i]), 32'(m_run[i]));
         chk($sformatf("%s.expired%0d", ph, i), 32'(expired[i]), 32'(m_exp[i]));
         chk($sformatf("%s.irq%0d", ph, i), 32'(irq[i]), 32'(m_irq[i]));
         chk($sformatf("%s.pwm%0d", ph, i), 32'(pwm[i]), 32'(m_pwm[i]));
      end
   endtask

   string phase = "init";

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all(phase);
   endtask

   initial begin
      int last;
      int highs;
      reset = 1'b0; prescale = '0; start = '0; stop = '0; periodic = '0;
      irq_clr = '0; reload = '0; compare = '0;
      #2;
      model_reset();
      check_all("reset");
      #10 reset = 1'b1;

      // one-shot countdown 3,2,1,0 then expiry
      phase = "oneshot";
      reload[0 +: WIDTH] = 16'd3; start[0] = 1'b1;
      step();
      start = '0;
      chk("oneshot_load", 32'(count[0 +: WIDTH]), 32'd3);
      step(); step(); step();
      chk("oneshot_zero", 32'(count[0 +: WIDTH]), 32'd0);
      chk("oneshot_run_at_zero", 32'(running[0]), 32'd1);
      step();
      chk("oneshot_expired", 32'(expired[0]), 32'd1);
      chk("oneshot_irq", 32'(irq[0]), 32'd1);
      chk("oneshot_stopped", 32'(running[0]), 32'd0);
      step();
      chk("oneshot_pulse_end", 32'(expired[0]), 32'd0);

      // periodic on ch1 with prescale 1: expiry every 6 clocks
      phase = "periodic";
      prescale = 8'd1;
      reload[WIDTH +: WIDTH] = 16'd2; periodic[1] = 1'b1; start[1] = 1'b1;
      step();
      start = '0;
      last = -1;
      for (int n = 0; n < 24; n++) begin
         step();
         if (expired[1]) begin
            if (last >= 0) chk("periodic_spacing", 32'(n - last), 32'd6);
            last = n;
         end
      end
      irq_clr[1] = 1'b1; step(); irq_clr = '0;
      stop[1] = 1'b1; step(); stop = '0;

      // stop holds the count; start together with stop is ignored
      phase = "stop";
      prescale = 8'd0;
      reload[0 +: WIDTH] = 16'd9; periodic[0] = 1'b0; start[0] = 1'b1;
      step();
      start = '0;
      step(); step(); step(); step();
      chk("stop_pre", 32'(count[0 +: WIDTH]), 32'd5);
      stop[0] = 1'b1; step(); stop = '0;
      chk("stop_hold", 32'(count[0 +: WIDTH]), 32'd5);
      chk("stop_idle", 32'(running[0]), 32'd0);
      step(); step(); step();
      chk("stop_still", 32'(count[0 +: WIDTH]), 32'd5);
      start[0] = 1'b1; stop[0] = 1'b1; step(); start = '0; stop = '0;
      chk("start_stop_idle", 32'(running[0]), 32'd0);

      // irq_clr colliding with expiry, then irq_clr alone
      phase = "irqclr";
      reload[0 +: WIDTH] = 16'd1; periodic[0] = 1'b1; start[0] = 1'b1; irq_clr[0] = 1'b1;
      step();
      start = '0; irq_clr = '0;
      step();
      irq_clr[0] = 1'b1; step(); irq_clr = '0;
      chk("clr_vs_expiry_exp", 32'(expired[0]), 32'd1);
      chk("clr_vs_expiry_irq", 32'(irq[0]), 32'd1);
      stop[0] = 1'b1; step(); stop = '0;
      irq_clr[0] = 1'b1; step(); irq_clr = '0;
      chk("clr_alone", 32'(irq[0]), 32'd0);

      // asynchronous reset between edges, then first tick after release
      phase = "areset";
      prescale = 8'd2;
      reload[WIDTH +: WIDTH] = 16'd5; periodic[1] = 1'b1; start[1] = 1'b1;
      step();
      start = '0;
      step(); step(); step(); step();
      #3 reset = 1'b0;
      #1;
      model_reset();
      check_all("areset_now");
      @(posedge clk);
      #3 reset = 1'b1;
      phase = "release";
      reload[0 +: WIDTH] = 16'd4; periodic[0] = 1'b0; start[0] = 1'b1;
      step();
      start = '0;
      chk("release_load", 32'(count[0 +: WIDTH]), 32'd4);
      chk("release_ch1_zero", 32'(count[WIDTH +: WIDTH]), 32'd0);
      step();
      chk("release_no_tick", 32'(count[0 +: WIDTH]), 32'd4);
      step();
      chk("release_first_tick", 32'(count[0 +: WIDTH]), 32'd3);
      stop = '1; step(); stop = '0;

`ifdef TIMER_MULTI_PWM_EN
      phase = "pwm";
      prescale = 8'd0;
      reload[0 +: WIDTH] = 16'd9; compare[0 +: WIDTH] = 16'd4; periodic[0] = 1'b1; start[0] = 1'b1;
      step();
      start = '0;
      for (int n = 0; n < 12; n++) step();
      highs = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (pwm[0]) highs++;
      end
      chk("pwm_duty", 32'(highs), 32'd4);
      stop = '1; step(); stop = '0;
`else
      highs = 0;
`endif

      // randomized traffic
      phase = "random";
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0) prescale = 8'($urandom_range(0, 3));
         for (int i = 0; i < CHANNELS; i++) begin
            start[i]    = ($urandom_range(0, 14) == 0);
            stop[i]     = ($urandom_range(0, 29) == 0);
            irq_clr[i]  = ($urandom_range(0, 9) == 0);
            periodic[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) reload[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) compare[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 9));
         end
         step();
      end
      start = '0; stop = '0; irq_clr = '0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_multi.md
# timer_multi

Parametrised multi-channel down-counting timer. It is the successor to the single-channel `timer` peripheral. It provides `CHANNELS` independent `WIDTH`-bit timers, all stepped by one shared programmable prescaler, each selectable as one-shot or periodic, with a per-channel expiry pulse and a sticky interrupt flag. It sits between the top-level control logic and the LED/IO pins of the Tang Nano 9K design.

## Interface
- `WIDTH`, 16, counter and reload/compare width per channel (≥2)
- `CHANNELS`, 2, number of independent timers (≥1)
- `PRESCALE_W`, 8, prescaler width

- `clk`  in  1  single system clock; all state rises on posedge
- `reset`  in  1  asynchronous, active-low reset
- `prescale`  in  PRESCALE_W  tick divider; one tick every prescale+1 clk cycles
- `start`  in  CHANNELS  per-channel pulse; load reload value and run
- `stop`  in  CHANNELS  per-channel pulse; halt and hold count
- `periodic`  in  CHANNELS  mode, sampled at start: 1 periodic, 0 one-shot
- `reload`  in  CHANNELS*WIDTH  per-channel load value; channel i uses bits [i*WIDTH +: WIDTH]
- `compare`  in  CHANNELS*WIDTH  per-channel PWM threshold (used only with `TIMER_MULTI_PWM_EN`)
- `irq_clr`  in  CHANNELS  per-channel clear of the sticky `irq`
- `count`  out  CHANNELS*WIDTH  current counter values
- `running`  out  CHANNELS  1 while the channel is in RUN
- `expired`  out  CHANNELS  one-clk pulse on expiry
- `irq`  out  CHANNELS  sticky expiry flag
- `pwm`  out  CHANNELS  registered PWM output

## Operation
- Prescaler: a free-running `pcnt` counts 0..`prescale`.
  - `tick`=1 in cycles where `pcnt==prescale`; `pcnt` then wraps to 0.
  - `prescale=0` gives a tick every cycle.
  - If `prescale` is lowered below `pcnt`, the compare uses `>=`, so `pcnt` wraps on the next cycle.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE/DONE/RUN + `start` → RUN. `count`←reload, mode←`periodic`. A start in RUN restarts the channel.
  - RUN + `stop` → IDLE. `count` holds, no expiry.
  - RUN + tick with `count!=0`: `count`←`count`-1.
  - RUN + tick with `count==0`: `expired`=1 for one cycle and `irq`←1.
    - Periodic: `count`←current `reload`, stay in RUN.
    - One-shot: → DONE, `count` holds 0.
  - DONE behaves as IDLE (`running`=0) except it records completion.
- Expiry period: (reload+1)*(prescale+1) clk cycles. `reload=0` in periodic mode expires on every tick.
- Simultaneous events:
  - `start` and `stop` on the same channel: stop wins.
  - `irq_clr` and expiry: set wins, `irq` stays 1.
  - `start` during a tick: start wins, no decrement.
- Channels are fully independent apart from the shared tick.
- Counter arithmetic is unsigned, WIDTH bits. `count` never underflows because expiry is taken at 0.

## Timing
- Reset (asynchronous, active-low): `pcnt`=0, all FSMs IDLE, and every output is 0 (`count`, `running`, `expired`, `irq`, `pwm`). Outputs clear immediately on assertion, without waiting for a clock edge.
- After reset release, the first tick occurs at posedge prescale+1.
- `start` sampled at edge k: `count`=reload and `running`=1 visible after edge k. The first decrement happens on the first tick at edge >k.
- `expired` and `irq` appear after the same edge where the zero-count tick is consumed.
- `running` falls after that same edge for one-shot mode, and after the `stop` edge for stop.
- `irq_clr` takes effect after the sampling edge.
- `pwm` lags `count` by one clk.

## Configuration
- Macro: `TIMER_MULTI_PWM_EN`.
- When defined:
  - Per channel, `pwm` is registered each clk as (state==RUN && `count` < `compare`).
  - `compare=0` keeps `pwm` at 0.
  - `compare>reload` keeps `pwm` at 1 while running.
- When undefined: `pwm` is constant 0, `compare` is ignored, and no comparator logic is synthesised. Ports are unchanged.

## Test plan
- `prescale`=0, ch0 `reload`=3, one-shot, `start` at edge k → `count` 3,2,1,0 after edges k..k+3. After edge k+4: `expired`=1 for one cycle, `irq`=1, `running`=0, `count` stays 0.
- `prescale`=1, ch1 `reload`=2, periodic → each `count` value is held 2 cycles. `expired` pulses every 6 cycles, and `irq` stays 1 until `irq_clr`.
- ch0 running with `count`=5, `stop` pulse → `count` holds 5, `running`=0, no `expired`. `start` and `stop` together → remains IDLE.
- `irq_clr` in the same cycle as expiry → `irq` stays 1. `irq_clr` alone → `irq`=0 next cycle.
- `reset` driven low mid-run, between clock edges → all outputs 0 immediately. After release, `count` stays 0 until the next `start`, and the first tick falls prescale+1 cycles after release.
- With `TIMER_MULTI_PWM_EN`: `prescale`=0, `reload`=9, `compare`=4, periodic → `pwm` high exactly 4 of every 10 cycles, one cycle after `count` reaches 3.
